operand_block_streamer: RTL



---
 rtl/operand_block_streamer.sv | 105 ++++++++++
 1 files changed

// File: rtl/operand_block_streamer.sv
// Streams two stored big-number operands as LSB-first block pairs into the block-serial multiplier.
// Optional SQUARE_MODE_EN: when defined, square_in latched at start makes m_out mirror the n block.
module operand_block_streamer #(
   parameter  int REGISTER_SIZE = 32,
   parameter  int BITS_IN_NUM   = 4096,
   localparam int BLOCKS        = BITS_IN_NUM / REGISTER_SIZE,
   localparam int AW            = $clog2(BLOCKS)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     wr_en_in,
   input  logic                     wr_sel_in,
   input  logic [AW-1:0]            wr_addr_in,
   input  logic [REGISTER_SIZE-1:0] wr_data_in,
   input  logic                     start_in,
   input  logic                     square_in,
   input  logic                     mult_ready_in,
   input  logic                     mult_final_in,
   output logic [REGISTER_SIZE-1:0] n_out,
   output logic [REGISTER_SIZE-1:0] m_out,
   output logic                     valid_out,
   output logic                     busy_out,
   output logic                     done_out
);

`ifdef SQUARE_MODE_EN
   localparam bit SQ_EN = 1'b1;
`else
   localparam bit SQ_EN = 1'b0;
`endif

   localparam logic [AW-1:0] LAST = AW'(BLOCKS - 1);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM, WAIT_FINAL} state_t;

   state_t                   state, state_nxt;
   logic                     pend, sq, done_q;
   logic [AW-1:0]            cnt, rd_addr;
   logic [REGISTER_SIZE-1:0] n_mem [BLOCKS];
   logic [REGISTER_SIZE-1:0] m_mem [BLOCKS];
   logic [REGISTER_SIZE-1:0] n_q, m_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if ((pend || start_in) && mult_ready_in) state_nxt = PRIME;
         PRIME:      state_nxt = STREAM;
         STREAM:     if (cnt == LAST) state_nxt = WAIT_FINAL;
         WAIT_FINAL: if (mult_final_in) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= IDLE;
         pend    <= 1'b0;
         sq      <= 1'b0;
         cnt     <= '0;
         rd_addr <= '0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == WAIT_FINAL) && mult_final_in;
         case (state)
            IDLE: begin
               if (start_in) sq <= square_in & SQ_EN;
               if (state_nxt == PRIME) begin
                  pend    <= 1'b0;
                  rd_addr <= '0;
                  cnt     <= '0;
               end else if (start_in) begin
                  pend <= 1'b1;
               end
            end
            // address 0 is being read this edge; queue block 1 behind it
            PRIME:  rd_addr <= AW'(1);
            STREAM: begin
               cnt <= cnt + AW'(1);
               if (rd_addr != LAST) rd_addr <= rd_addr + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // operand storage survives reset; host writes only land while idle
   always_ff @(posedge clk_in) begin
      if (wr_en_in && (state == IDLE)) begin
         if (wr_sel_in) m_mem[wr_addr_in] <= wr_data_in;
         else           n_mem[wr_addr_in] <= wr_data_in;
      end
      n_q <= n_mem[rd_addr];
      if (!sq) m_q <= m_mem[rd_addr];
   end

   always_comb begin
      valid_out = (state == STREAM);
      busy_out  = (state != IDLE);
      done_out  = done_q;
      n_out     = valid_out ? n_q : '0;
      m_out     = valid_out ? (sq ? n_q : m_q) : '0;
   end

endmodule
